scroll_display_mux: RTL

Parameterised scrolling, time-multiplexed 7-segment display controller. It snapshots a message of `MSG_LEN` hex symbols with per-symbol decimal point and blank flags, and scrolls a `NUM_DIGITS`-wide window circularly across the message at a programmable rate. It drives the digits one at a time through active-low anode selects. It sits between the counter/clock datapath (Johnson counter, hours/minutes BCD, DP LED) and the board display pins.

---
 rtl/scroll_display_mux.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/scroll_display_mux.sv
// rtl/scroll_display_mux.sv - scrolling, time-multiplexed 7-segment display controller
// Snapshots a circular message and scans a NUM_DIGITS window of it onto active-low digit pins.
module scroll_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_LEN     = 6,
    parameter int SCROLL_DIV  = 12_500_000,
    parameter int REFRESH_DIV = 50_000,
    parameter int AUTO_RELOAD = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    load,
    input  logic [4*MSG_LEN-1:0]    sym_in,
    input  logic [MSG_LEN-1:0]      dp_in,
    input  logic [MSG_LEN-1:0]      blank_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    wrap
);

    localparam int OFS_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SC_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int RF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(MSG_LEN - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCROLL_DIV - 1);
    localparam logic [RF_W-1:0]  RF_LAST  = RF_W'(REFRESH_DIV - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SC_W-1:0]         sc_q, sc_d;
    logic [RF_W-1:0]         rf_q, rf_d;
    logic [DIG_W-1:0]        dig_q, dig_d;
    logic [OFS_W-1:0]        ofs_q, ofs_d;
    logic [4*MSG_LEN-1:0]    sym_q, sym_d;
    logic [MSG_LEN-1:0]      dpb_q, dpb_d;
    logic [MSG_LEN-1:0]      blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    wrap_q, wrap_d;

    logic                    tick;
    logic                    reload;
    logic [31:0]             pos;
    logic [OFS_W-1:0]        idx;
    logic [3:0]              cur_sym;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Message entry shown on the currently scanned digit; the window wraps circularly.
    always_comb begin
        pos     = 32'(ofs_q) + 32'(dig_q);
        idx     = OFS_W'(pos % 32'(MSG_LEN));
        cur_sym = sym_q[4*idx +: 4];
    end

    always_comb begin
        state_d = enable ? ST_RUN : ST_BLANK;
        sc_d    = sc_q;
        rf_d    = rf_q;
        dig_d   = dig_q;
        ofs_d   = ofs_q;
        tick    = 1'b0;
        wrap_d  = 1'b0;
        an_d    = '1;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;

        case (state_q)
            ST_BLANK: begin
                sc_d  = '0;
                rf_d  = '0;
                dig_d = '0;
            end
            default: begin
                an_d = ~(NUM_DIGITS'(1) << dig_q);
                if (!blank_q[idx]) begin
                    seg_d = hex7(cur_sym);
                    dp_d  = ~dpb_q[idx];
                end
                if (!enable) begin
                    sc_d  = '0;
                    rf_d  = '0;
                    dig_d = '0;
                end else begin
                    if (rf_q == RF_LAST) begin
                        rf_d  = '0;
                        dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
                    end else begin
                        rf_d = rf_q + RF_W'(1);
                    end
                    if (mode) begin
                        sc_d = '0;
                    end else if (sc_q == SC_LAST) begin
                        sc_d = '0;
                        tick = 1'b1;
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end
        endcase

        if (tick) begin
            ofs_d  = (ofs_q == OFS_LAST) ? '0 : ofs_q + OFS_W'(1);
            wrap_d = (ofs_q == OFS_LAST);
        end

        // A load coinciding with an auto-reload is a single snapshot of the same inputs.
        reload  = load || ((AUTO_RELOAD != 0) && wrap_d);
        sym_d   = reload ? sym_in   : sym_q;
        dpb_d   = reload ? dp_in    : dpb_q;
        blank_d = reload ? blank_in : blank_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BLANK;
            sc_q    <= '0;
            rf_q    <= '0;
            dig_q   <= '0;
            ofs_q   <= '0;
            sym_q   <= '0;
            dpb_q   <= '0;
            blank_q <= '1;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            rf_q    <= rf_d;
            dig_q   <= dig_d;
            ofs_q   <= ofs_d;
            sym_q   <= sym_d;
            dpb_q   <= dpb_d;
            blank_q <= blank_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            wrap_q  <= wrap_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign wrap = wrap_q;

endmodule
